// File: rtl/mips_mem_pkg.sv
// Shared types and default sizing for the data-memory responder.
//   mem_size_e    : access size encoding carried on req_size
//   dmem_state_e  : responder FSM states
//   DMEM_*        : default geometry/timing used as parameter defaults
package mips_mem_pkg;

  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_ADDR_W  = 12;
  localparam int DMEM_DEPTH   = 1024;
  localparam int DMEM_LATENCY = 2;
  localparam int BYTES        = DMEM_DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port data RAM with per-byte write enables and a registered read.
// Contents are never reset.
//   clk     : clock
//   i_en    : access strobe (read or write this cycle)
//   i_we    : 1 = write selected byte lanes, 0 = read whole word
//   i_be    : byte-lane write enables
//   i_addr  : word index
//   i_wdata : write data, already lane-aligned
//   o_rdata : read data, valid the cycle after a read strobe
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int NB     = BYTES,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [NB-1:0]     i_be,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < NB; b++) begin
          if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs it after
// LATENCY cycles and holds the response until the initiator takes it.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake
//   req_we/size/addr/wdata: request fields (size: byte/half/word/reserved)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : zero-extended load data, 0 for stores/errors
//   rsp_err               : reserved size, misaligned or out-of-range
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | counting down the access latency; access fires when count hits 0
// RESP  | response presented, waiting for rsp_ready
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);

  dmem_state_e       r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_we;
  mem_size_e         r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [1:0]        w_off;
  logic              w_oob;
  logic              w_err;
  logic              w_ram_en;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata_sh;
  logic [DATA_W-1:0] w_ram_q;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_size  <= mem_size_e'(req_size);
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) w_state_nxt = RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields stay latched through RESP, so the error flag and the
  // lane selection remain stable for the whole response.
  assign w_off = r_addr[1:0];
  assign w_oob = int'(r_addr[ADDR_W-1:2]) >= DEPTH;
  assign w_err = (r_size == SZ_RSVD)
              || (r_size == SZ_HALF && r_addr[0])
              || (r_size == SZ_WORD && r_addr[1:0] != 2'b00)
              || w_oob;

  always_comb begin
    case (r_size)
      SZ_BYTE: w_be = NB'(1) << w_off;
      SZ_HALF: w_be = NB'(3) << w_off;
      default: w_be = '1;
    endcase
  end

  assign w_wdata_sh = r_wdata << (8 * w_off);
  // The RAM fires on the BUSY->RESP edge; its registered read lands in RESP.
  assign w_ram_en   = (r_state == BUSY) && (r_cnt == 4'd0) && !w_err;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NB     (NB),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (r_we),
    .i_be    (w_be),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (w_wdata_sh),
    .o_rdata (w_ram_q)
  );

  assign w_shift = w_ram_q >> (8 * w_off);

  always_comb begin
    case (r_size)
      SZ_BYTE: w_load = DATA_W'(w_shift[7:0]);
      SZ_HALF: w_load = DATA_W'(w_shift[15:0]);
      default: w_load = w_shift;
    endcase
  end

  assign rsp_rdata = (rsp_valid && !r_we && !w_err) ? w_load : '0;
  assign rsp_err   = rsp_valid && w_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic [11:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  dmem_responder #(.DATA_W(32), .ADDR_W(12), .DEPTH(1024), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DATA_W(32), .ADDR_W(12), .DEPTH(512), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int dep_of(int d);
    return (d == 0) ? 1024 : 512;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  // Behavioural model: byte-addressed memory, one outstanding request,
  // response due a fixed number of edges after acceptance.
  logic [7:0]  m_mem   [2][4096];
  bit          m_pend  [2] = '{0, 0};
  bit          m_rsp   [2] = '{0, 0};
  bit          m_ready [2] = '{1, 1};
  int          m_due   [2];
  bit          m_we    [2];
  logic [1:0]  m_sz    [2];
  logic [11:0] m_a     [2];
  logic [31:0] m_wd    [2];
  logic [31:0] m_rdata [2];
  bit          m_err   [2];

  task automatic model_access(input int d);
    int a = int'(m_a[d]);
    int n = (m_sz[d] == 2'd0) ? 1 : (m_sz[d] == 2'd1) ? 2 : 4;
    m_err[d] = (m_sz[d] == 2'd3) || (m_sz[d] == 2'd1 && a % 2 != 0) ||
               (m_sz[d] == 2'd2 && a % 4 != 0) || (a / 4 >= dep_of(d));
    m_rdata[d] = 32'h0;
    if (!m_err[d]) begin
      for (int i = 0; i < n; i++) begin
        if (m_we[d]) m_mem[d][a+i] = m_wd[d][8*i +: 8];
        else         m_rdata[d] = m_rdata[d] | (32'(m_mem[d][a+i]) << (8*i));
      end
    end
  endtask

  task automatic model_step(input int d);
    if (!rst_n) begin
      m_pend[d] = 0;
      m_rsp[d]  = 0;
    end else if (m_rsp[d]) begin
      if (rsp_ready[d]) m_rsp[d] = 0;
    end else if (m_pend[d]) begin
      if (cyc == m_due[d]) begin
        model_access(d);
        m_pend[d] = 0;
        m_rsp[d]  = 1;
      end
    end else if (req_valid[d]) begin
      m_we[d]   = req_we[d];
      m_sz[d]   = req_size[d];
      m_a[d]    = req_addr[d];
      m_wd[d]   = req_wdata[d];
      m_pend[d] = 1;
      m_due[d]  = cyc + lat_of(d);
    end
    m_ready[d] = !m_pend[d] && !m_rsp[d];
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) model_step(d);
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk("rst_req_ready", d, 32'(req_ready[d]), 32'd1);
        chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
        chk("rst_rsp_rdata", d, rsp_rdata[d], 32'd0);
        chk("rst_rsp_err",   d, 32'(rsp_err[d]), 32'd0);
      end else begin
        chk("req_ready", d, 32'(req_ready[d]), 32'(m_ready[d]));
        chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(m_rsp[d]));
        if (m_rsp[d]) begin
          chk("rsp_rdata", d, rsp_rdata[d], m_rdata[d]);
          chk("rsp_err",   d, 32'(rsp_err[d]), 32'(m_err[d]));
        end
      end
    end
  end

  logic [31:0] last_rdata;
  logic        last_err;

  task automatic drive_req(input int d, input bit we, input logic [1:0] sz,
                           input logic [11:0] a, input logic [31:0] wd);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_size[d]  = sz;
    req_addr[d]  = a;
    req_wdata[d] = wd;
  endtask

  task automatic wait_accept(input int d, output int acc);
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        acc = cyc + 1;
        @(posedge clk);
        #2;
        req_valid[d] = 1'b0;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got no req_ready within 50 cycles", d);
    end
  endtask

  task automatic wait_resp(input int d, output int rc);
    rc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin
        rc         = cyc;
        last_rdata = rsp_rdata[d];
        last_err   = rsp_err[d];
        break;
      end
    end
    if (rc < 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout dut%0d: got no rsp_valid within 50 cycles", d);
    end else if (rsp_ready[d]) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic xact(input int d, input bit we, input logic [1:0] sz,
                      input logic [11:0] a, input logic [31:0] wd, output int acc);
    int rc;
    drive_req(d, we, sz, a, wd);
    wait_accept(d, acc);
    rsp_ready[d] = 1'b1;
    wait_resp(d, rc);
    chk("latency", d, 32'(rc - acc), 32'(lat_of(d)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, acc2, rc, hs;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_size[d]  = 2'd0;
      req_addr[d]  = 12'h0;
      req_wdata[d] = 32'h0;
      rsp_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready_lit", 0, 32'(req_ready[0]), 32'd1);
    chk("reset_valid_lit", 0, 32'(rsp_valid[0]), 32'd0);
    @(posedge clk);
    #2;

    // word store then load
    xact(0, 1'b1, 2'b10, 12'h010, 32'hDEADBEEF, acc);
    chk("t1_store_err", 0, 32'(last_err), 32'd0);
    chk("t1_store_rdata", 0, last_rdata, 32'd0);
    xact(0, 1'b0, 2'b10, 12'h010, 32'h0, acc);
    chk("t1_load", 0, last_rdata, 32'hDEADBEEF);

    // bytes 0x10..0x13 = EF BE AD DE; byte 0x13 <- AA, half 0x10 <- 34 12
    xact(0, 1'b1, 2'b00, 12'h013, 32'h000000AA, acc);
    xact(0, 1'b1, 2'b01, 12'h010, 32'h00001234, acc);
    xact(0, 1'b0, 2'b10, 12'h010, 32'h0, acc);
    chk("t2_word", 0, last_rdata, 32'hAAAD1234);
    xact(0, 1'b0, 2'b00, 12'h012, 32'h0, acc);
    chk("t2_byte", 0, last_rdata, 32'h000000AD);
    xact(0, 1'b0, 2'b01, 12'h012, 32'h0, acc);
    chk("t2_half", 0, last_rdata, 32'h0000AAAD);

    // error cases leave RAM untouched
    xact(0, 1'b0, 2'b01, 12'h011, 32'h0, acc);
    chk("t3_half_mis_err", 0, 32'(last_err), 32'd1);
    chk("t3_half_mis_rdata", 0, last_rdata, 32'd0);
    xact(0, 1'b1, 2'b10, 12'h012, 32'h11111111, acc);
    chk("t3_word_mis_err", 0, 32'(last_err), 32'd1);
    xact(0, 1'b1, 2'b11, 12'h010, 32'h22222222, acc);
    chk("t3_rsvd_err", 0, 32'(last_err), 32'd1);
    xact(0, 1'b0, 2'b10, 12'h010, 32'h0, acc);
    chk("t3_unchanged", 0, last_rdata, 32'hAAAD1234);
    chk("t3_unchanged_err", 0, 32'(last_err), 32'd0);

    // backpressure: response held, new request waits behind it
    drive_req(0, 1'b0, 2'b10, 12'h010, 32'h0);
    wait_accept(0, acc);
    rsp_ready[0] = 1'b0;
    wait_resp(0, rc);
    chk("t4_latency", 0, 32'(rc - acc), 32'd2);
    chk("t4_rdata", 0, last_rdata, 32'hAAAD1234);
    @(posedge clk);
    #2;
    drive_req(0, 1'b0, 2'b00, 12'h012, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 0, 32'(rsp_valid[0]), 32'd1);
      chk("t4_hold_rdata", 0, rsp_rdata[0], 32'hAAAD1234);
      chk("t4_hold_ready", 0, 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk);
    #2;
    rsp_ready[0] = 1'b1;
    hs = cyc + 1;
    wait_accept(0, acc);
    chk("t4_next_accept", 0, 32'(acc), 32'(hs + 1));
    wait_resp(0, rc);
    chk("t4_next_rdata", 0, last_rdata, 32'h000000AD);

    // reset while a store is in BUSY
    xact(0, 1'b1, 2'b10, 12'h020, 32'h0A0B0C0D, acc);
    drive_req(0, 1'b1, 2'b00, 12'h020, 32'h00000055);
    wait_accept(0, acc);
    rst_n = 1'b0;
    #1;
    chk("t5_async_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("t5_async_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("t5_async_rdata", 0, rsp_rdata[0], 32'd0);
    chk("t5_async_err", 0, 32'(rsp_err[0]), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    xact(0, 1'b0, 2'b10, 12'h020, 32'h0, acc);
    chk("t5_old_value", 0, last_rdata, 32'h0A0B0C0D);

    // LATENCY=1, DEPTH=512 build
    xact(1, 1'b1, 2'b10, 12'h100, 32'hCAFEF00D, acc);
    xact(1, 1'b0, 2'b10, 12'h100, 32'h0, acc2);
    chk("t6_b2b_period", 1, 32'(acc2 - acc), 32'd3);
    chk("t6_load", 1, last_rdata, 32'hCAFEF00D);
    xact(1, 1'b0, 2'b00, 12'h103, 32'h0, acc);
    chk("t6_b2b_period2", 1, 32'(acc - acc2), 32'd3);
    chk("t6_byte", 1, last_rdata, 32'h000000CA);
    xact(1, 1'b1, 2'b10, 12'h7FC, 32'h01020304, acc);
    chk("t6_top_word_err", 1, 32'(last_err), 32'd0);
    xact(1, 1'b0, 2'b10, 12'h7FC, 32'h0, acc);
    chk("t6_top_word", 1, last_rdata, 32'h01020304);
    xact(1, 1'b1, 2'b10, 12'h800, 32'h00000005, acc);
    chk("t6_oob_err", 1, 32'(last_err), 32'd1);
    xact(1, 1'b0, 2'b00, 12'hFFF, 32'h0, acc);
    chk("t6_oob_byte_err", 1, 32'(last_err), 32'd1);
    chk("t6_oob_rdata", 1, last_rdata, 32'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
